// File: rtl/vga_pkg.sv
// Shared VGA constants and the packed timing-bus layout used by the sprite overlay path.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned V_ACTIVE = 768;

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned POS_W  = 12;
    localparam int unsigned ADDR_W = 12;

    localparam int unsigned SPR_W_DEF = 48;
    localparam int unsigned SPR_H_DEF = 64;
    localparam logic [RGB_W-1:0] TRANSP_RGB_DEF = 12'hF0F;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
    } timing_t;

    localparam int unsigned TIMING_W = $bits(timing_t);

    // 13-bit operands so lo+len can never wrap for 12-bit positions.
    function automatic logic in_span(input logic [12:0] c, input logic [12:0] lo,
                                     input logic [12:0] len);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-latency shift register for a packed bus; resets every stage to zero.
module signal_delay #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [CLK_DEL-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(CLK_DEL); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: addresses the external sprite ROM and merges its colour into the
// pixel stream, keeping all timing signals aligned with a fixed 2-clock latency.
module draw_sprite
    import vga_pkg::*;
#(
    parameter int unsigned       SPR_W      = SPR_W_DEF,
    parameter int unsigned       SPR_H      = SPR_H_DEF,
    parameter logic [RGB_W-1:0]  TRANSP_RGB = TRANSP_RGB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [POS_W-1:0]  xpos,
    input  logic [POS_W-1:0]  ypos,
    input  logic [RGB_W-1:0]  rom_rgb,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [CNT_W-1:0]  hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    logic             vsync_prev;
    logic [POS_W-1:0] x_lat;
    logic [POS_W-1:0] y_lat;

    // Position only moves on a vsync rising edge so a frame is never drawn torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    logic       hit;
    logic [5:0] x_rel;
    logic [5:0] y_rel;

    always_comb begin
        hit = in_span({2'b00, hcount_in}, {1'b0, x_lat}, 13'(SPR_W)) &&
              in_span({2'b00, vcount_in}, {1'b0, y_lat}, 13'(SPR_H));
        // Low bits of a difference depend only on the low bits of the operands.
        x_rel = hcount_in[5:0] - x_lat[5:0];
        y_rel = vcount_in[5:0] - y_lat[5:0];
    end

    logic [RGB_W-1:0] rgb1;
    logic             hit1;
    logic             blank1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb1       <= '0;
            hit1       <= 1'b0;
            blank1     <= 1'b0;
            pixel_addr <= '0;
        end else begin
            rgb1       <= rgb_in;
            hit1       <= hit;
            blank1     <= hblnk_in | vblnk_in;
            pixel_addr <= hit ? {y_rel, x_rel} : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out <= '0;
        end else if (blank1) begin
            rgb_out <= '0;
        end else if (hit1 && (rom_rgb != TRANSP_RGB)) begin
            rgb_out <= rom_rgb;
        end else begin
            rgb_out <= rgb1;
        end
    end

    timing_t timing_in;
    timing_t timing_out;

    assign timing_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                         vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    signal_delay #(
        .WIDTH   (TIMING_W),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_out)
    );

    assign hcount_out = timing_out.hcount;
    assign hsync_out  = timing_out.hsync;
    assign hblnk_out  = timing_out.hblnk;
    assign vcount_out = timing_out.vcount;
    assign vsync_out  = timing_out.vsync;
    assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite: a reference model queues expected address/pixel results
// per input pixel, and a negedge monitor compares them as the DUT pipeline delivers them.
module tb_draw_sprite;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos, rom_rgb, pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    logic [11:0] rom [4096];
    assign rom_rgb = rom[pixel_addr];

    always #5 clk = ~clk;

    draw_sprite dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .rom_rgb    (rom_rgb),
        .pixel_addr (pixel_addr),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    typedef struct {
        int          cyc;
        logic [11:0] addr;
    } addr_exp_t;

    typedef struct {
        int          cyc;
        logic [25:0] timing;
        logic [11:0] rgb;
    } out_exp_t;

    addr_exp_t addr_q[$];
    out_exp_t  out_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: sprite position as of the last vsync rising edge seen.
    int   mx = 0;
    int   my = 0;
    logic m_prev_vs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives one pixel, queues its expected result, returns at posedge+1.
    task automatic apply(input int h, input logic hs, input logic hb, input int v,
                         input logic vs, input logic vb, input logic [11:0] rgb);
        logic        hit;
        logic [11:0] a;
        logic [11:0] e;
        hcount_in = 11'(h);
        hsync_in  = hs;
        hblnk_in  = hb;
        vcount_in = 11'(v);
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = rgb;
        hit = (h >= mx) && (h < mx + 48) && (v >= my) && (v < my + 64);
        a   = hit ? 12'((v - my) * 64 + (h - mx)) : 12'h000;
        if (hb || vb)                         e = 12'h000;
        else if (hit && rom[a] != 12'hF0F)    e = rom[a];
        else                                  e = rgb;
        addr_q.push_back('{cyc: cyc, addr: a});
        out_q.push_back('{cyc: cyc, timing: {11'(h), hs, hb, 11'(v), vs, vb}, rgb: e});
        if (vs && !m_prev_vs) begin
            mx = int'(xpos);
            my = int'(ypos);
        end
        m_prev_vs = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        apply(0, 1'b0, 1'b1, 770, 1'b1, 1'b1, 12'h000);
        apply(0, 1'b0, 1'b1, 770, 1'b1, 1'b1, 12'h000);
        apply(0, 1'b0, 1'b1, 771, 1'b0, 1'b1, 12'h000);
    endtask

    // Compact raster: active window plus a short blank tail per line and per frame.
    task automatic frame(input int hs0, input int hw, input int vs0, input int vh,
                         input int tear_line, input logic [11:0] tear_x);
        for (int v = vs0; v < vs0 + vh + 4; v++) begin
            for (int h = hs0; h < hs0 + hw + 6; h++) begin
                if (v == tear_line && h == hs0) xpos = tear_x;
                apply(h, (h >= hs0 + hw + 2) && (h < hs0 + hw + 4), h >= hs0 + hw,
                      v, v == vs0 + vh + 2, v >= vs0 + vh, 12'($urandom));
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr"}, 32'(pixel_addr), 32'h0);
        check({tag, "_rgb"}, 32'(rgb_out), 32'h0);
        check({tag, "_timing"},
              32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}), 32'h0);
    endtask

    task automatic do_reset_release();
        addr_q.delete();
        out_q.delete();
        mx = 0;
        my = 0;
        m_prev_vs = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
        vsync_in = 0; vblnk_in = 0; rgb_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : monitor
        addr_exp_t ae;
        out_exp_t  oe;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (addr_q.size() > 0 && addr_q[0].cyc + 1 == cyc) begin
                    ae = addr_q.pop_front();
                    check("pixel_addr", 32'(pixel_addr), 32'(ae.addr));
                end
                if (out_q.size() > 0 && out_q[0].cyc + 2 == cyc) begin
                    oe = out_q.pop_front();
                    check("rgb_out", 32'(rgb_out), 32'(oe.rgb));
                    check("timing_out",
                          32'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                               vblnk_out}), 32'(oe.timing));
                end
            end
        end
    end

    initial begin : driver
        int h;
        int v;
        logic vs;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
        end
        rom[12'h000] = 12'h0F0;
        rom[12'h001] = 12'hF0F;
        rom[{6'd63, 6'd47}] = 12'hABC;

        rst  = 1'b1;
        xpos = '0;
        ypos = '0;
        #1;
        check_zero_outputs("por");
        do_reset_release();

        // Position defaults to (0,0) after reset.
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) apply(x, 1'b0, 1'b0, y, 1'b0, 1'b0, 12'h123);
        end

        xpos = 12'd100;
        ypos = 12'd50;
        vsync_pulse();
        apply(100, 1'b0, 1'b0, 50, 1'b0, 1'b0, 12'h123);
        apply(101, 1'b0, 1'b0, 50, 1'b0, 1'b0, 12'h123);
        apply(147, 1'b0, 1'b0, 113, 1'b0, 1'b0, 12'h123);
        apply(99, 1'b0, 1'b0, 50, 1'b0, 1'b0, 12'h123);
        apply(148, 1'b0, 1'b0, 50, 1'b0, 1'b0, 12'h123);
        apply(100, 1'b0, 1'b0, 49, 1'b0, 1'b0, 12'h123);
        apply(100, 1'b0, 1'b0, 114, 1'b0, 1'b0, 12'h123);
        apply(147, 1'b0, 1'b0, 114, 1'b0, 1'b0, 12'h123);
        apply(148, 1'b0, 1'b0, 113, 1'b0, 1'b0, 12'h123);
        apply(120, 1'b0, 1'b1, 60, 1'b0, 1'b0, 12'h123);

        // Reset asserted mid-line must clear outputs without waiting for a clock.
        for (int x = 110; x < 116; x++) apply(x, 1'b0, 1'b0, 60, 1'b0, 1'b0, 12'($urandom));
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midline_rst");
        @(posedge clk);
        #1;
        do_reset_release();
        for (int x = 0; x < 6; x++) apply(x, 1'b0, 1'b0, 3, 1'b0, 1'b0, 12'h456);

        xpos = 12'd100;
        ypos = 12'd50;
        vsync_pulse();
        // xpos moves mid-frame; the sprite must stay put until the frame's vsync.
        frame(80, 100, 40, 80, 70, 12'd300);
        frame(280, 100, 40, 80, -1, 12'd0);

        for (int f = 0; f < 3; f++) begin
            xpos = 12'($urandom_range(0, 100));
            ypos = 12'($urandom_range(0, 40));
            frame(0, 120, 0, 90, -1, 12'd0);
        end

        // Sprite hanging off the right/bottom screen edges.
        xpos = 12'd2020;
        ypos = 12'd1000;
        vsync_pulse();
        frame(1980, 62, 990, 60, -1, 12'd0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                xpos = 12'($urandom);
                ypos = 12'($urandom);
            end
            vs = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                h = mx + int'($urandom_range(0, 56)) - 4;
                v = my + int'($urandom_range(0, 72)) - 4;
            end else begin
                h = int'($urandom_range(0, 2047));
                v = int'($urandom_range(0, 2047));
            end
            if (h < 0) h = 0;
            if (h > 2047) h = 2047;
            if (v < 0) v = 0;
            if (v > 2047) v = 2047;
            apply(h, 1'($urandom), $urandom_range(0, 5) == 0, v, vs,
                  vs | ($urandom_range(0, 5) == 0), 12'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        check("drain_addr_q", 32'(addr_q.size()), 32'h0);
        check("drain_out_q", 32'(out_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
